// File: rtl/grid_nbr_fetch.sv
// Neighbour-fetch engine: reads the N/E/S/W neighbours of a grid cell from the grid SRAM.
// Define GRID_NBR_TORUS_WRAP_EN to wrap edge neighbours around the grid as a torus.
module grid_nbr_fetch #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int GRID_W      = 8,
    parameter int GRID_H      = 8,
    parameter int COORD_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [COORD_WIDTH-1:0]  x,
    input  logic [COORD_WIDTH-1:0]  y,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [4*DATA_WIDTH-1:0] nbr_data,
    output logic [3:0]              nbr_valid,
    output logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    cs,
    output logic                    we
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_N = 3'd1;
    localparam logic [2:0] S_RD_E = 3'd2;
    localparam logic [2:0] S_RD_S = 3'd3;
    localparam logic [2:0] S_RD_W = 3'd4;
    localparam logic [2:0] S_CAP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [31:0]            GW_U    = GRID_W;
    localparam logic [31:0]            GH_U    = GRID_H;
    localparam logic [31:0]            GW_LAST = GW_U - 32'd1;
    localparam logic [31:0]            GH_LAST = GH_U - 32'd1;
    localparam logic [COORD_WIDTH-1:0] C_ONE   = COORD_WIDTH'(1);

    logic [2:0]             state;
    logic [COORD_WIDTH-1:0] cx, cy;
    logic [ADDR_WIDTH-1:0]  addr_hold;
    logic                   coord_ok;
    logic                   at_top, at_bottom, at_left, at_right;
    logic [COORD_WIDTH-1:0] n_y, s_y, e_x, w_x;
    logic [3:0]             nbr_inb;
    logic [ADDR_WIDTH-1:0]  nbr_addr [4];
    logic                   rd_state;
    logic [1:0]             rd_slot;
    logic                   vld_p1;
    logic [1:0]             slot_p1;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [COORD_WIDTH-1:0] px,
                                                        input logic [COORD_WIDTH-1:0] py);
        return ADDR_WIDTH'(py) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(px);
    endfunction

    assign coord_ok = (32'(x) < GW_U) && (32'(y) < GH_U);

    assign at_top    = (cy == '0);
    assign at_left   = (cx == '0);
    assign at_bottom = (32'(cy) == GH_LAST);
    assign at_right  = (32'(cx) == GW_LAST);

    // Edge tests select the neighbour coordinate before any address arithmetic.
    always_comb begin
        n_y = cy - C_ONE;
        s_y = cy + C_ONE;
        e_x = cx + C_ONE;
        w_x = cx - C_ONE;
`ifdef GRID_NBR_TORUS_WRAP_EN
        if (at_top)    n_y = COORD_WIDTH'(GRID_H - 1);
        if (at_bottom) s_y = '0;
        if (at_right)  e_x = '0;
        if (at_left)   w_x = COORD_WIDTH'(GRID_W - 1);
        nbr_inb = 4'b1111;
`else
        nbr_inb = {~at_left, ~at_bottom, ~at_right, ~at_top};
`endif
    end

    assign nbr_addr[0] = cell_addr(cx, n_y);
    assign nbr_addr[1] = cell_addr(e_x, cy);
    assign nbr_addr[2] = cell_addr(cx, s_y);
    assign nbr_addr[3] = cell_addr(w_x, cy);

    assign rd_state = (state >= S_RD_N) && (state <= S_RD_W);
    assign rd_slot  = 2'(state - S_RD_N);
    assign cs       = rd_state && nbr_inb[rd_slot];
    assign address  = cs ? nbr_addr[rd_slot] : addr_hold;
    assign we       = 1'b0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            addr_hold <= '0;
            vld_p1    <= 1'b0;
            slot_p1   <= '0;
            nbr_data  <= '0;
            nbr_valid <= '0;
            err       <= 1'b0;
        end else begin
            // Issue stage -> capture stage: SRAM data returns one cycle after cs.
            vld_p1  <= cs;
            slot_p1 <= rd_slot;
            if (cs) addr_hold <= address;
            if (vld_p1) begin
                nbr_data[32'(slot_p1)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                nbr_valid[slot_p1] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cx        <= x;
                        cy        <= y;
                        nbr_data  <= '0;
                        nbr_valid <= '0;
                        err       <= ~coord_ok;
                        state     <= coord_ok ? S_RD_N : S_DONE;
                    end
                end
                S_RD_N:  state <= S_RD_E;
                S_RD_E:  state <= S_RD_S;
                S_RD_S:  state <= S_RD_W;
                S_RD_W:  state <= S_CAP;
                S_CAP:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
